// File: rtl/mtimer.sv
// Machine timer: free-running 64-bit mtime with prescaler, 64-bit mtimecmp,
// both bus-mapped as XLEN-wide halves; o_timer = (mtime >= mtimecmp).
module mtimer #(
  parameter int unsigned XLEN = 32,
  parameter int unsigned DIV  = 1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            i_req,
  input  logic            i_we,
  input  logic [3:0]      i_addr,
  input  logic [XLEN-1:0] i_wdata,
  input  logic [3:0]      i_be,
  output logic [XLEN-1:0] o_rdata,
  output logic            o_ack,
  input  logic            i_debug,
  input  logic            i_stopcount,
  output logic            o_timer
);

  localparam int unsigned PW = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int unsigned NB = ((XLEN / 8) < 4) ? (XLEN / 8) : 4;

  logic [63:0]     r_mtime;
  logic [63:0]     r_mtimecmp;
  logic [PW-1:0]   r_pcnt;
  logic [XLEN-1:0] r_rdata;
  logic            r_ack;
  logic            r_timer;

  logic [63:0]     w_mtime_nxt;
  logic [63:0]     w_cmp_nxt;
  logic [PW-1:0]   w_pcnt_nxt;
  logic [XLEN-1:0] w_wmask;
  logic [XLEN-1:0] w_rd_half;
  logic [XLEN-1:0] w_new_half;
  logic            w_count_en;
  logic            w_tick;
  logic            w_wr_time;
  logic            w_wr_cmp;
  logic            w_unused;

  assign w_count_en = !(i_debug && i_stopcount);
  assign w_tick     = w_count_en && (r_pcnt == PW'(DIV - 1));
  assign w_wr_time  = i_req && i_we && !i_addr[3];
  assign w_wr_cmp   = i_req && i_we && i_addr[3];
  assign w_unused   = ^i_addr[1:0];

  always_comb begin
    w_wmask = '0;
    for (int i = 0; i < int'(NB); i++) begin
      w_wmask[8*i +: 8] = {8{i_be[i]}};
    end
  end

  // Addressed half as currently stored: read data and byte-merge base
  always_comb begin
    w_rd_half = '0;
    unique case (i_addr[3:2])
      2'd0: w_rd_half = r_mtime[0 +: XLEN];
      2'd1: w_rd_half = r_mtime[XLEN +: XLEN];
      2'd2: w_rd_half = r_mtimecmp[0 +: XLEN];
      2'd3: w_rd_half = r_mtimecmp[XLEN +: XLEN];
      default: w_rd_half = '0;
    endcase
  end

  assign w_new_half = (w_rd_half & ~w_wmask) | (i_wdata & w_wmask);

  // Next state; an mtime write overrides that cycle's increment and restarts the prescaler
  always_comb begin
    w_mtime_nxt = r_mtime;
    w_cmp_nxt   = r_mtimecmp;
    w_pcnt_nxt  = r_pcnt;
    if (w_count_en) begin
      w_pcnt_nxt = w_tick ? '0 : r_pcnt + PW'(1);
      if (w_tick) begin
        w_mtime_nxt = r_mtime + 64'd1;
      end
    end
    if (w_wr_time) begin
      w_mtime_nxt = r_mtime;
      w_pcnt_nxt  = '0;
      if (i_addr[2]) begin
        w_mtime_nxt[XLEN +: XLEN] = w_new_half;
      end else begin
        w_mtime_nxt[0 +: XLEN] = w_new_half;
      end
    end
    if (w_wr_cmp) begin
      if (i_addr[2]) begin
        w_cmp_nxt[XLEN +: XLEN] = w_new_half;
      end else begin
        w_cmp_nxt[0 +: XLEN] = w_new_half;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_mtime    <= '0;
      r_mtimecmp <= '1;
      r_pcnt     <= '0;
      r_timer    <= 1'b0;
    end else begin
      r_mtime    <= w_mtime_nxt;
      r_mtimecmp <= w_cmp_nxt;
      r_pcnt     <= w_pcnt_nxt;
      r_timer    <= (w_mtime_nxt >= w_cmp_nxt);
    end
  end

  // Single-cycle bus response; rdata is zero whenever ack is low or for writes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ack   <= 1'b0;
      r_rdata <= '0;
    end else begin
      r_ack   <= i_req;
      r_rdata <= (i_req && !i_we) ? w_rd_half : '0;
    end
  end

  assign o_rdata = r_rdata;
  assign o_ack   = r_ack;
  assign o_timer = r_timer;

endmodule

// File: tb/tb_mtimer.sv
// Scoreboard bench for mtimer: DIV=1 and DIV=4 instances share one bus and
// are checked against a 64-bit arithmetic reference model.
module tb_mtimer;

  logic        clk       = 1'b0;
  logic        rst_n     = 1'b0;
  logic        req       = 1'b0;
  logic        we        = 1'b0;
  logic [3:0]  addr      = 4'h0;
  logic [31:0] wdata     = 32'h0;
  logic [3:0]  be        = 4'h0;
  logic        debug     = 1'b0;
  logic        stopcount = 1'b0;

  logic [31:0] rdata0, rdata1;
  logic [1:0]  ack, timer;

  int checks   = 0;
  int failures = 0;
  logic mon_en = 1'b0;

  always #5 clk = ~clk;

  mtimer #(.XLEN(32), .DIV(1)) u_d1 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_be(be), .o_rdata(rdata0), .o_ack(ack[0]),
    .i_debug(debug), .i_stopcount(stopcount), .o_timer(timer[0])
  );

  mtimer #(.XLEN(32), .DIV(4)) u_d4 (
    .clk(clk), .rst_n(rst_n), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .i_be(be), .o_rdata(rdata1), .o_ack(ack[1]),
    .i_debug(debug), .i_stopcount(stopcount), .o_timer(timer[1])
  );

  // Reference model state
  logic [63:0] m_time  [2];
  logic [63:0] m_cmp   [2];
  int unsigned m_pcnt  [2];
  logic        m_timer [2];
  logic [31:0] exp_q0 [$];
  logic [31:0] exp_q1 [$];

  function automatic int unsigned div_of(input int k);
    return (k == 0) ? 1 : 4;
  endfunction

  function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] d,
                                        input logic [3:0] b);
    logic [31:0] r;
    r = old;
    for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = d[8*i +: 8];
    return r;
  endfunction

  function automatic void chk(input string nm, input int k, input logic [63:0] act,
                              input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s[div%0d] t=%0t actual=%h expected=%h", nm, div_of(k), $time, act, exp);
    end
  endfunction

  always @(posedge clk or negedge rst_n) begin : model
    logic [63:0] t, c;
    int unsigned p;
    logic [31:0] rv;
    if (!rst_n) begin
      for (int k = 0; k < 2; k++) begin
        m_time[k]  <= 64'h0;
        m_cmp[k]   <= '1;
        m_pcnt[k]  <= 0;
        m_timer[k] <= 1'b0;
      end
      exp_q0.delete();
      exp_q1.delete();
    end else begin
      for (int k = 0; k < 2; k++) begin
        t = m_time[k];
        c = m_cmp[k];
        p = m_pcnt[k];
        if (req) begin
          case (addr[3:2])
            2'd0:    rv = t[31:0];
            2'd1:    rv = t[63:32];
            2'd2:    rv = c[31:0];
            default: rv = c[63:32];
          endcase
          if (we) rv = 32'h0;
          if (k == 0) exp_q0.push_back(rv);
          else        exp_q1.push_back(rv);
        end
        if (!(debug && stopcount)) begin
          p = p + 1;
          if (p == div_of(k)) begin
            p = 0;
            t = t + 64'd1;
          end
        end
        if (req && we) begin
          case (addr[3:2])
            2'd0: begin t = {m_time[k][63:32], merge(m_time[k][31:0], wdata, be)}; p = 0; end
            2'd1: begin t = {merge(m_time[k][63:32], wdata, be), m_time[k][31:0]}; p = 0; end
            2'd2: c = {c[63:32], merge(c[31:0], wdata, be)};
            default: c = {merge(c[63:32], wdata, be), c[31:0]};
          endcase
        end
        m_time[k]  <= t;
        m_cmp[k]   <= c;
        m_pcnt[k]  <= p;
        m_timer[k] <= (t >= c);
      end
    end
  end

  function automatic void check_bus(input int k, input logic a, input logic [31:0] d);
    int sz;
    logic [31:0] e;
    sz = (k == 0) ? exp_q0.size() : exp_q1.size();
    if (a) begin
      if (sz == 0) begin
        chk("spurious_ack", k, 64'(a), 64'(1'b0));
      end else begin
        e = (k == 0) ? exp_q0.pop_front() : exp_q1.pop_front();
        chk("rdata", k, 64'(d), 64'(e));
      end
    end else begin
      if (sz != 0) begin
        if (k == 0) void'(exp_q0.pop_front());
        else        void'(exp_q1.pop_front());
        chk("missing_ack", k, 64'(a), 64'(1'b1));
      end
      chk("idle_rdata", k, 64'(d), 64'h0);
    end
  endfunction

  // Monitor: registered outputs sampled on the falling edge
  always @(negedge clk) begin
    if (mon_en) begin
      chk("timer", 0, 64'(timer[0]), 64'(m_timer[0]));
      chk("timer", 1, 64'(timer[1]), 64'(m_timer[1]));
      check_bus(0, ack[0], rdata0);
      check_bus(1, ack[1], rdata1);
    end
  end

  task automatic drive(input logic r, input logic w, input logic [3:0] a,
                       input logic [31:0] d, input logic [3:0] b);
    req = r; we = w; addr = a; wdata = d; be = b;
    @(negedge clk);
  endtask

  task automatic idle(input int n);
    repeat (n) drive(1'b0, 1'b0, 4'h0, 32'h0, 4'h0);
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d, input logic [3:0] b);
    drive(1'b1, 1'b1, a, d, b);
  endtask

  task automatic rd(input logic [3:0] a);
    drive(1'b1, 1'b0, a, 32'h0, 4'h0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    mon_en = 1'b1;
    chk("reset_ack", 0, 64'(ack[0]), 64'h0);
    chk("reset_timer", 1, 64'(timer[1]), 64'h0);
    rst_n = 1'b1;

    // Idle count and reset values
    idle(10);
    rd(4'h0);
    rd(4'hC);
    idle(1);

    // Low-half wrap carries into high half
    wr(4'h0, 32'hFFFF_FFFE, 4'hF);
    wr(4'h4, 32'h0, 4'hF);
    idle(1);
    rd(4'h4);
    rd(4'h0);
    idle(8);
    rd(4'h4);

    // Compare at 20, then raise compare above mtime
    wr(4'hC, 32'h0, 4'hF);
    wr(4'h8, 32'd20, 4'hF);
    wr(4'h4, 32'h0, 4'hF);
    wr(4'h0, 32'h0, 4'hF);
    idle(85);
    wr(4'h8, 32'd100, 4'hF);
    idle(3);

    // mtime wrap drops timer below a small compare
    wr(4'h8, 32'd5, 4'hF);
    wr(4'h4, 32'hFFFF_FFFF, 4'hF);
    wr(4'h0, 32'hFFFF_FFF8, 4'hF);
    idle(45);
    rd(4'h4);

    // Debug freeze and resume
    debug = 1'b1; stopcount = 1'b1;
    idle(50);
    rd(4'h0);
    stopcount = 1'b0;
    idle(10);
    rd(4'h0);
    debug = 1'b0;

    // Byte-enable partial write
    wr(4'h8, 32'h0000_AB00, 4'b0010);
    rd(4'h8);
    rd(4'hC);

    // Reset before the read is sampled
    req = 1'b1; we = 1'b0; addr = 4'h4;
    #2 rst_n = 1'b0;
    @(negedge clk);
    req = 1'b0; rst_n = 1'b1;
    idle(2);
    // Reset while the ack is being presented
    req = 1'b1; we = 1'b0; addr = 4'hC;
    @(posedge clk);
    #2 rst_n = 1'b0; req = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    idle(3);
    rd(4'hC);
    idle(1);

    // Randomized traffic
    for (int n = 0; n < 1500; n++) begin
      logic [31:0] d;
      if ($urandom_range(0, 19) == 0) begin
        debug     = ($urandom_range(0, 2) == 0);
        stopcount = 1'($urandom_range(0, 1));
      end
      if ($urandom_range(0, 99) < 40) begin
        case ($urandom_range(0, 3))
          0:       d = $urandom;
          1:       d = 32'($urandom_range(0, 300));
          2:       d = 32'hFFFF_FFFF;
          default: d = 32'h0;
        endcase
        drive(1'b1, 1'($urandom_range(0, 1)), 4'($urandom_range(0, 15)), d,
              4'($urandom_range(0, 15)));
      end else begin
        idle(1);
      end
    end
    debug = 1'b0;
    idle(3);
    mon_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
